// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Byte FIFO feeding an RS-232C transmitter (8N1, LSB first).
//            Define UART_TX_PARITY_EN for 8E1 frames with an even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int WAIT_CYCLES = 868,
  parameter int DEPTH_LOG2  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_send_data,
  input  logic [7:0] send_data,
  output logic       txd,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int                  c_DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL      = (DEPTH_LOG2 + 1)'(c_DEPTH);
  localparam logic [15:0]         c_BAUD_LAST = 16'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_next;
  logic [15:0]           r_baud;
  logic [15:0]           w_baud_next;
  logic [2:0]            r_bit_idx;
  logic [2:0]            w_bit_next;
  logic [7:0]            r_shift;
  logic [7:0]            w_shift_next;
  logic                  r_txd;
  logic                  w_txd_next;
  logic                  r_tx_busy;
  logic                  r_fifo_full;
  logic                  r_overflow;
  logic                  w_pop;
  logic                  w_push_ok;
  logic                  w_drop;
  logic                  w_baud_done;
  logic [7:0]            w_head;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
  logic                  w_parity_next;
`endif

  assign txd       = r_txd;
  assign tx_busy   = r_tx_busy;
  assign fifo_full = r_fifo_full;
  assign overflow  = r_overflow;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_baud_done = (r_baud == c_BAUD_LAST);
  // A push into a full FIFO still lands when the head leaves on the same edge.
  assign w_push_ok   = push_send_data && ((r_count != c_FULL) || w_pop);
  assign w_drop      = push_send_data && !w_push_ok;

  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = w_baud_done ? 16'd0 : r_baud + 16'd1;
    w_bit_next    = r_bit_idx;
    w_shift_next  = r_shift;
    w_pop         = 1'b0;
    w_txd_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        w_baud_next = 16'd0;
        if (r_count != '0) begin
          w_pop         = 1'b1;
          w_shift_next  = w_head;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^w_head;
`endif
          w_state_next  = S_START;
        end
      end
      S_START: begin
        w_txd_next = 1'b0;
        if (w_baud_done) begin
          w_state_next = S_DATA;
          w_bit_next   = 3'd0;
        end
      end
      S_DATA: begin
        w_txd_next = r_shift[0];
        if (w_baud_done) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          w_bit_next   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        w_txd_next = r_parity;
        if (w_baud_done) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        w_txd_next = 1'b1;
        if (w_baud_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // txd follows the registered state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_baud    <= 16'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_next;
      r_shift   <= w_shift_next;
      r_txd     <= w_txd_next;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_fifo_full <= 1'b0;
      r_tx_busy   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_next;
      r_fifo_full <= (w_count_next == c_FULL);
      r_tx_busy   <= (w_count_next != '0) || (w_state_next != S_IDLE);
      r_overflow  <= r_overflow | w_drop;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !reset) r_mem[r_wr_ptr] <= send_data;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench for uart_tx_fifo against a cycle-level
//            queue/timing model; honours UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int W     = 4;
  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * W + 1;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       push  = 1'b0;
  logic [7:0] data  = 8'd0;
  logic       txd;
  logic       tx_busy;
  logic       fifo_full;
  logic       overflow;

  always #5 clk = ~clk;

  uart_tx_fifo #(.WAIT_CYCLES(W), .DEPTH_LOG2(DL)) dut (
    .clk            (clk),
    .reset          (reset),
    .push_send_data (push),
    .send_data      (data),
    .txd            (txd),
    .tx_busy        (tx_busy),
    .fifo_full      (fifo_full),
    .overflow       (overflow)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int e        = 0;

  // Model: queue of accepted bytes, edge of the last pop and earliest next pop.
  logic [7:0] q[$];
  int         next_pop = 0;
  int         lp       = -100000;
  logic [7:0] lb       = 8'd0;
  logic       m_ovf    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, e);
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic step(input logic r, input logic p, input logic [7:0] d);
    int   sz;
    int   t;
    logic pop;
    logic exp_txd;
    logic exp_busy;
    @(negedge clk);
    reset = r;
    push  = p;
    data  = d;
    @(posedge clk);
    e++;
    if (r) begin
      q.delete();
      next_pop = 0;
      lp       = -100000;
      m_ovf    = 1'b0;
    end else begin
      sz  = q.size();
      pop = (sz > 0) && (e >= next_pop);
      if (pop) begin
        lb       = q.pop_front();
        lp       = e;
        next_pop = e + FRAME;
      end
      if (p) begin
        if (sz < DEPTH || pop) q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    #1;
    t        = e - lp - 1;
    exp_txd  = (t >= 0 && t < FRAME - 1) ? frame_bit(lb, t / W) : 1'b1;
    exp_busy = (q.size() != 0) || (e >= lp && e < lp + FRAME - 1);
    check_eq("txd",       txd,       exp_txd);
    check_eq("tx_busy",   tx_busy,   exp_busy);
    check_eq("fifo_full", fifo_full, q.size() == DEPTH);
    check_eq("overflow",  overflow,  m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    int pct;
    logic [7:0] burst [3];
    burst[0] = 8'h01; burst[1] = 8'h02; burst[2] = 8'h03;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0);
    idle(50);

    step(1'b0, 1'b1, 8'hA5);
    idle(50);

    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, burst[i]);
    idle(3 * FRAME + 10);

    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
    check_eq("burst_full", fifo_full, 1'b1);
    check_eq("burst_ovf",  overflow,  1'b1);
    idle(5 * FRAME + 10);
    check_eq("ovf_sticky", overflow, 1'b1);

    // Reset lands during the third data bit of the 8'hFF frame.
    step(1'b0, 1'b1, 8'hFF);
    idle(14);
    step(1'b1, 1'b0, 8'd0);
    check_eq("rst_txd",  txd,      1'b1);
    check_eq("rst_busy", tx_busy,  1'b0);
    check_eq("rst_ovf",  overflow, 1'b0);
    idle(60);
    step(1'b0, 1'b1, 8'h3C);
    idle(FRAME + 10);

    for (int blk = 0; blk < 20; blk++) begin
      case ($urandom_range(0, 3))
        0:       pct = 1;
        1:       pct = 5;
        2:       pct = 30;
        default: pct = 90;
      endcase
      for (int i = 0; i < 100; i++)
        step($urandom_range(0, 599) == 0, $urandom_range(0, 99) < pct, 8'($urandom));
    end
    idle((DEPTH + 1) * FRAME + 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
